// File: rtl/ws2812_pkg.sv
// Shared types, constants and helpers for the WS2812 pixel feeder.
package ws2812_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      PRESENT = 2'd2,
      LATCH   = 2'd3
   } state_t;

   typedef logic [23:0] rgb_t;
   typedef logic [23:0] grb_t;

   localparam int RGB_R_LSB = 16;
   localparam int RGB_G_LSB = 8;
   localparam int RGB_B_LSB = 0;

   localparam int GRB_G_LSB = 16;
   localparam int GRB_R_LSB = 8;
   localparam int GRB_B_LSB = 0;

   // Clock cycles spanned by a gap of 'us' microseconds.
   function automatic logic [31:0] latch_cycles(input int unsigned clk_fre, input int unsigned us);
      return (clk_fre / 32'd1_000_000) * us;
   endfunction

   // Host writes RGB; the LED chain expects GRB on the wire.
   function automatic grb_t rgb_to_grb(input rgb_t rgb);
      grb_t grb;
      grb = '0;
      grb[GRB_G_LSB +: 8] = rgb[RGB_G_LSB +: 8];
      grb[GRB_R_LSB +: 8] = rgb[RGB_R_LSB +: 8];
      grb[GRB_B_LSB +: 8] = rgb[RGB_B_LSB +: 8];
      return grb;
   endfunction

   // (c * (b + 1)) >> 8 so that b = 255 is the identity.
   function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
      logic [15:0] prod;
      prod = 16'(c) * (16'(b) + 16'd1);
      return prod[15:8];
   endfunction

   function automatic rgb_t scale_rgb(input rgb_t rgb, input logic [7:0] b);
      rgb_t res;
      res = '0;
      res[RGB_R_LSB +: 8] = scale_chan(rgb[RGB_R_LSB +: 8], b);
      res[RGB_G_LSB +: 8] = scale_chan(rgb[RGB_G_LSB +: 8], b);
      res[RGB_B_LSB +: 8] = scale_chan(rgb[RGB_B_LSB +: 8], b);
      return res;
   endfunction

endpackage

// File: rtl/ws2812_pixel_ram.sv
// Pixel store: one write port, one registered read port (read-old-data on
// a same-address collision). Written to map onto block RAM, so no reset on
// the array or the read register.
module ws2812_pixel_ram
   import ws2812_pkg::*;
#(
   parameter int NUM_LEDS = 8,
   parameter int ADDR_W   = 3
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  rgb_t              wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output rgb_t              rd_data
);

   // Storage covers the full address range so any index is legal to the
   // array; entries at or above NUM_LEDS are never written.
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] NUM_LEDS_W = (ADDR_W + 1)'(NUM_LEDS);

   rgb_t mem [DEPTH];

   // Write port; out-of-range pixel indices are dropped.
   always_ff @(posedge clk) begin
      if (wr_en && ({1'b0, wr_addr} < NUM_LEDS_W)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered read port; holds its value while rd_en is low.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/ws2812_pixel_feeder.sv
// WS2812 pixel feeder: streams the pixel RAM in GRB order to the bit
// serializer over valid/ready, then holds off for the latch gap.
// Optional build macro: WS2812_BRIGHTNESS_EN (global brightness scaling,
// adds one pipeline stage to each pixel fetch).
//
// state   | meaning
// IDLE    | waiting for a frame request (or a pending one)
// FETCH   | reading pixel 'idx' from RAM (1 cycle, 2 with brightness)
// PRESENT | pix_valid high, waiting for pix_ready
// LATCH   | counting down the latch gap, busy still high
module ws2812_pixel_feeder
   import ws2812_pkg::*;
#(
   parameter int NUM_LEDS = 8,
   parameter int ADDR_W   = 3,
   parameter int CLK_FRE  = 27_000_000,
   parameter int LATCH_US = 80
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [23:0]       wr_rgb,
   input  logic [7:0]        brightness,
   input  logic              frame_start,
   output logic              busy,
   output logic              frame_done,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [23:0]       pix_data,
   output logic              pix_last
);

   localparam logic [31:0]       LATCH_CYC  = latch_cycles(CLK_FRE, LATCH_US);
   localparam logic [31:0]       LATCH_LOAD = (LATCH_CYC == 32'd0) ? 32'd0 : LATCH_CYC - 32'd1;
   localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_LEDS - 1);

`ifdef WS2812_BRIGHTNESS_EN
   localparam logic FETCH_PH_LAST = 1'b1;
`else
   localparam logic FETCH_PH_LAST = 1'b0;
`endif

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              pending_q, pending_d;
   logic [31:0]       latch_cnt_q, latch_cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              valid_q, valid_d;
   logic              fetch_ph_q, fetch_ph_d;
   logic              rd_en;
   rgb_t              rd_data;
   grb_t              pix_grb;

   ws2812_pixel_ram #(
      .NUM_LEDS (NUM_LEDS),
      .ADDR_W   (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_rgb),
      .rd_en   (rd_en),
      .rd_addr (idx_q),
      .rd_data (rd_data)
   );

`ifdef WS2812_BRIGHTNESS_EN
   grb_t scl_q;

   // Second fetch phase: scale the freshly read pixel and reorder to GRB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_q <= '0;
      end else if (state_q == FETCH && fetch_ph_q) begin
         scl_q <= rgb_to_grb(scale_rgb(rd_data, brightness));
      end
   end

   assign pix_grb = scl_q;
`else
   logic brightness_unused;
   assign brightness_unused = ^brightness;
   assign pix_grb           = rgb_to_grb(rd_data);
`endif

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      pending_d   = pending_q;
      latch_cnt_d = latch_cnt_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      valid_d     = valid_q;
      fetch_ph_d  = fetch_ph_q;
      rd_en       = 1'b0;

      // Requests arriving mid-frame collapse into a single pending frame.
      if (frame_start && state_q != IDLE) begin
         pending_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (frame_start || pending_q) begin
               busy_d     = 1'b1;
               idx_d      = '0;
               pending_d  = 1'b0;
               fetch_ph_d = 1'b0;
               state_d    = FETCH;
            end
         end
         FETCH: begin
            rd_en = !fetch_ph_q;
            if (fetch_ph_q == FETCH_PH_LAST) begin
               fetch_ph_d = 1'b0;
               valid_d    = 1'b1;
               state_d    = PRESENT;
            end else begin
               fetch_ph_d = 1'b1;
            end
         end
         PRESENT: begin
            if (valid_q && pix_ready) begin
               valid_d = 1'b0;
               if (idx_q == LAST_IDX) begin
                  idx_d       = '0;
                  latch_cnt_d = LATCH_LOAD;
                  state_d     = LATCH;
               end else begin
                  idx_d   = idx_q + ADDR_W'(1);
                  state_d = FETCH;
               end
            end
         end
         LATCH: begin
            if (latch_cnt_q == 32'd0) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               latch_cnt_d = latch_cnt_q - 32'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         pending_q   <= 1'b0;
         latch_cnt_q <= 32'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         valid_q     <= 1'b0;
         fetch_ph_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         pending_q   <= pending_d;
         latch_cnt_q <= latch_cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         valid_q     <= valid_d;
         fetch_ph_q  <= fetch_ph_d;
      end
   end

   assign busy       = busy_q;
   assign frame_done = done_q;
   assign pix_valid  = valid_q;
   assign pix_data   = valid_q ? pix_grb : 24'h0;
   assign pix_last   = valid_q && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_ws2812_pixel_feeder.sv
// Directed, self-checking bench for ws2812_pixel_feeder.
module tb_ws2812_pixel_feeder;

   localparam int NUM_LEDS  = 8;
   localparam int ADDR_W    = 4;
   localparam int LATCH_CYC = 2160;
`ifdef WS2812_BRIGHTNESS_EN
   localparam int EXP_LAT = 3;
`else
   localparam int EXP_LAT = 2;
`endif

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [23:0]       rgb;
      logic [23:0]       grb;
   } pix_vec_t;

   logic              clk;
   logic              rst;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [23:0]       wr_rgb;
   logic [7:0]        brightness;
   logic              frame_start;
   logic              busy;
   logic              frame_done;
   logic              pix_valid;
   logic              pix_ready;
   logic [23:0]       pix_data;
   logic              pix_last;

   int checks   = 0;
   int failures = 0;

   pix_vec_t    vec [8];
   logic [23:0] exp_px [8];

   ws2812_pixel_feeder #(
      .NUM_LEDS (NUM_LEDS),
      .ADDR_W   (ADDR_W),
      .CLK_FRE  (27_000_000),
      .LATCH_US (80)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_rgb      (wr_rgb),
      .brightness  (brightness),
      .frame_start (frame_start),
      .busy        (busy),
      .frame_done  (frame_done),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .pix_data    (pix_data),
      .pix_last    (pix_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_px(input logic [ADDR_W-1:0] a, input logic [23:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_rgb  = d;
      tick();
      wr_en = 1'b0;
   endtask

   // Wait for pixel k, check it, optionally stall, then accept it.
   task automatic consume(input int k, input int stall_n, input bit pulse, output int waited);
      int n;
      n = 0;
      while (!pix_valid && n < 20) begin
         tick();
         n++;
      end
      waited = n;
      check("valid_seen", 32'(pix_valid), 32'd1);
      if (!pix_valid) return;
      check("px_data", 32'(pix_data), 32'(exp_px[k]));
      check("px_last", 32'(pix_last), 32'(k == NUM_LEDS - 1));
      for (int i = 0; i < stall_n; i++) begin
         if (pulse) frame_start = (i % 3 == 0) && (i < 9);
         tick();
         check("stall_valid", 32'(pix_valid), 32'd1);
         check("stall_data", 32'(pix_data), 32'(exp_px[k]));
         check("stall_last", 32'(pix_last), 32'(k == NUM_LEDS - 1));
      end
      frame_start = 1'b0;
      pix_ready   = 1'b1;
      tick();
      check("drop_after_accept", 32'(pix_valid), 32'd0);
   endtask

   // One complete frame through the latch gap; returns in the frame_done cycle.
   task automatic run_frame(input bit do_start, input int stall_px, input int stall_n,
                            input bit pulse, input bit tear);
      int lat;
      int w;
      int n;
      lat = 0;
      if (do_start) begin
         frame_start = 1'b1;
         tick();
         frame_start = 1'b0;
         lat = 1;
      end
      for (int k = 0; k < NUM_LEDS; k++) begin
         consume(k, (k == stall_px) ? stall_n : 0, pulse, w);
         if (k == 0 && do_start) check("first_latency", lat + w, EXP_LAT);
         if (tear && k == 4) begin
            wr_en   = 1'b1;
            wr_addr = 4'd5;
            wr_rgb  = 24'hA1B2C3;
            tick();
            wr_en = 1'b0;
         end
      end
      check("latch_busy", 32'(busy), 32'd1);
      n = 0;
      while (!frame_done && n < 3000) begin
         tick();
         n++;
      end
      check("latch_len", n, LATCH_CYC);
      check("done_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      int n_done;
      int n_busy;
      int w;

      vec[0] = '{4'd0, 24'h010203, 24'h020103};
      vec[1] = '{4'd1, 24'h020304, 24'h030204};
      vec[2] = '{4'd2, 24'h030405, 24'h040305};
      vec[3] = '{4'd3, 24'h040506, 24'h050406};
      vec[4] = '{4'd4, 24'h050607, 24'h060507};
      vec[5] = '{4'd5, 24'h060708, 24'h070608};
      vec[6] = '{4'd6, 24'h070809, 24'h080709};
      vec[7] = '{4'd7, 24'h08090A, 24'h09080A};

      rst         = 1'b1;
      wr_en       = 1'b0;
      wr_addr     = '0;
      wr_rgb      = '0;
      brightness  = 8'd255;
      frame_start = 1'b0;
      pix_ready   = 1'b1;
      tick();
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(frame_done), 32'd0);
      check("rst_valid", 32'(pix_valid), 32'd0);
      check("rst_data", 32'(pix_data), 32'd0);
      check("rst_last", 32'(pix_last), 32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < NUM_LEDS; i++) begin
         write_px(vec[i].addr, vec[i].rgb);
         exp_px[i] = vec[i].grb;
      end

      // Plain frame, ready tied high.
      run_frame(1'b1, -1, 0, 1'b0, 1'b0);
      tick();
      check("done_pulse_width", 32'(frame_done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);

      // Stall on pixel 0 with three merged requests during the frame.
      pix_ready = 1'b0;
      run_frame(1'b1, 0, 10, 1'b1, 1'b0);
      tick();
      check("pending_start", 32'(busy), 32'd1);
      run_frame(1'b0, -1, 0, 1'b0, 1'b0);
      n_busy = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (busy || pix_valid) n_busy++;
      end
      check("no_extra_frame", n_busy, 0);

      // Same-address write/read collision on pixel 5, then start on done.
      run_frame(1'b1, -1, 0, 1'b0, 1'b1);
      frame_start = 1'b1;
      wr_en       = 1'b1;
      wr_addr     = 4'd9;
      wr_rgb      = 24'hDEADBE;
      tick();
      frame_start = 1'b0;
      wr_en       = 1'b0;
      check("start_on_done", 32'(busy), 32'd1);
      exp_px[5] = 24'hB2A1C3;
      run_frame(1'b0, -1, 0, 1'b0, 1'b0);

      // Reset while pixel 4 is presented, with a request pending.
      tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      for (int k = 0; k < 4; k++) consume(k, 0, 1'b0, w);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      n_done = 0;
      while (!pix_valid && n_done < 20) begin
         tick();
         n_done++;
      end
      check("px4_seen", 32'(pix_valid), 32'd1);
      check("px4_data", 32'(pix_data), 32'(exp_px[4]));
      rst = 1'b1;
      #1;
      check("async_rst_valid", 32'(pix_valid), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      tick();
      tick();
      rst    = 1'b0;
      n_done = 0;
      n_busy = 0;
      for (int i = 0; i < 2300; i++) begin
         tick();
         if (frame_done) n_done++;
         if (busy) n_busy++;
      end
      check("rst_no_done", n_done, 0);
      check("rst_pending_cleared", n_busy, 0);
      run_frame(1'b1, -1, 0, 1'b0, 1'b0);

`ifdef WS2812_BRIGHTNESS_EN
      tick();
      brightness = 8'd127;
      write_px(4'd0, 24'hFF8040);
      exp_px[0] = 24'h407F20;
      exp_px[1] = 24'h010102;
      exp_px[2] = 24'h020102;
      exp_px[3] = 24'h020203;
      exp_px[4] = 24'h030203;
      exp_px[5] = 24'h595061;
      exp_px[6] = 24'h040304;
      exp_px[7] = 24'h040405;
      run_frame(1'b1, -1, 0, 1'b0, 1'b0);
      tick();
      brightness = 8'd255;
      for (int i = 1; i < NUM_LEDS; i++) exp_px[i] = vec[i].grb;
      exp_px[0] = 24'h80FF40;
      exp_px[5] = 24'hB2A1C3;
      run_frame(1'b1, -1, 0, 1'b0, 1'b0);
`endif

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ws2812_pixel_feeder.md
Name: ws2812_pixel_feeder

Overview:
- Upstream stage of the WS2812 bit serializer.
- Holds an NUM_LEDS-deep 24-bit pixel RAM that host logic writes in RGB order.
- On a frame request, streams the pixels in GRB order over a valid/ready handshake to the serializer. It then enforces the >50 us latch gap before reporting the frame done.

Parameters:
- NUM_LEDS, 8: number of LEDs in the chain (pixel RAM depth), 1..256.
- ADDR_W, 3: address width, equal to clog2(NUM_LEDS), minimum 1.
- CLK_FRE, 27_000_000: clock frequency in Hz.
- LATCH_US, 80: latch/reset gap in microseconds after the last pixel.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- wr_en  in  1  pixel RAM write strobe.
- wr_addr  in  ADDR_W  pixel index to write; values >= NUM_LEDS are ignored.
- wr_rgb  in  24  pixel colour: R[23:16], G[15:8], B[7:0].
- brightness  in  8  global brightness; used only with the optional feature.
- frame_start  in  1  single-cycle frame request.
- busy  out  1  high from frame acceptance until the end of the latch gap.
- frame_done  out  1  one-cycle pulse when the latch gap ends.
- pix_valid  out  1  pix_data holds a pixel.
- pix_ready  in  1  downstream accepts the pixel on valid&&ready.
- pix_data  out  24  pixel in GRB order: G[23:16], R[15:8], B[7:0].
- pix_last  out  1  qualifies the pixel at index NUM_LEDS-1.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Output reset values: busy=0, frame_done=0, pix_valid=0, pix_data=0, pix_last=0. State=IDLE, pixel index=0, pending=0, latch counter=0.
- RAM contents are not reset.
- Pixel RAM: one write port, one registered read port with 1-cycle latency.
  - A read and a write to the same address in the same cycle return the old data.
  - Writes are allowed during a frame. A pixel is sampled when it is fetched, so tearing is permitted.
- State machine IDLE -> FETCH -> PRESENT -> (FETCH | LATCH) -> IDLE.
- IDLE: frame_start or pending=1 -> busy=1, index=0, pending=0, go to FETCH.
- FETCH: issue a RAM read at index; on the next cycle load pix_data (reordered to GRB), set pix_valid=1 and pix_last=(index==NUM_LEDS-1), go to PRESENT.
  - Latency from frame_start to first pix_valid is 2 cycles (3 with the optional feature).
- PRESENT: pix_data and pix_last stay stable while pix_valid && !pix_ready.
  - On acceptance, pix_valid drops for at least one cycle (one pixel in flight; no back-to-back).
  - If not last: index+1, go to FETCH.
  - If last: index=0, go to LATCH.
- LATCH: count CLK_FRE/1_000_000*LATCH_US cycles (2160 at defaults) with pix_valid=0 and busy=1. Then pulse frame_done for one cycle together with busy->0, and go to IDLE.
- frame_start while busy: sets pending=1 (single-deep; further requests are merged). The pending frame starts the cycle after frame_done.
- frame_start in the same cycle as frame_done: treated as pending and starts the next cycle.
- The latch counter is 32 bits wide and does not wrap.
- NUM_LEDS=1: the first pixel has pix_last=1.
- Reset mid-frame: immediate return to IDLE, pix_valid=0, no frame_done, pending cleared.

Optional Feature:
- Macro: WS2812_BRIGHTNESS_EN.
- Defined: each channel out = (c * (brightness+1)) >> 8, computed in 16-bit unsigned arithmetic and truncated to 8 bits. brightness=255 gives the identity.
  - One extra register stage sits between the RAM read and pix_data, so FETCH takes 2 cycles.
- Undefined: the brightness port is ignored, the channel values pass unmodified, and FETCH takes 1 cycle.

Decomposition:
- Shared package ws2812_pkg holds:
  - state encoding constants (IDLE/FETCH/PRESENT/LATCH);
  - the GRB byte-position constants;
  - the helper function for latch cycles = CLK_FRE/1_000_000*US;
  - the pixel typedef: 24-bit rgb_t and grb_t.
- Sub-module ws2812_pixel_ram: NUM_LEDS x 24 simple dual-port RAM with a registered read port and inferable BSRAM.

Test Plan:
- Write pixels 0..7 = 24'h010203 + i*24'h010101; frame_start with pix_ready tied high.
  - Expect 8 handshakes, first pix_data = 24'h020103, pix_last only on the 8th.
  - Expect frame_done exactly 2160 cycles after the 8th acceptance; busy then 0.
- pix_ready held low 10 cycles after the first pix_valid.
  - Expect pix_data stable, pix_valid held, no index advance; pixel accepted on the cycle ready rises.
- frame_start pulsed 3 times during a frame.
  - Expect exactly one extra frame, starting the cycle after frame_done; busy stays high across the boundary except for the done cycle.
- rst asserted mid-stream after pixel 3 is accepted.
  - Expect pix_valid=0 and busy=0 asynchronously, no frame_done.
  - A new frame_start restarts from pixel 0.
- Write to addr 5 in the same cycle FETCH reads addr 5.
  - Expect old value out this frame, new value next frame.
  - Write to addr 9 with NUM_LEDS=8 leaves the RAM unchanged.
- With WS2812_BRIGHTNESS_EN defined:
  - brightness=127 and pixel 24'hFF8040 -> pix_data 24'h407F20.
  - brightness=255 -> 24'h80FF40.
